// File: rtl/ctrl_burst_act.sv
// Row-activation stage of the DDR controller: tracks open rows per bank and issues
// ACTIVATE/PRECHARGE decisions while honouring tRRD, tFAW and tRP.
package ddr_pkg;
    localparam logic [2:0] RD_R  = 3'd0;
    localparam logic [2:0] RDA_R = 3'd1;
    localparam logic [2:0] WR_R  = 3'd2;
    localparam logic [2:0] WRA_R = 3'd3;
endpackage

module ctrl_burst_act
    import ddr_pkg::*;
#(
    parameter int NUM_BANKS = 16,
    parameter int ROW_W     = 16,
    parameter int tRRD      = 4,
    parameter int tFAW      = 16,
    parameter int tRP       = 11,
    localparam int BANK_W   = $clog2(NUM_BANKS)
) (
    input  logic              CK_t,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_rw,
    input  logic [BANK_W-1:0] req_bank,
    input  logic [ROW_W-1:0]  req_row,
    input  logic              close_all,
    output logic              act_rdy,
    output logic              no_act_rdy,
    output logic [2:0]        act_rw,
    output logic [BANK_W-1:0] act_bank,
    output logic [ROW_W-1:0]  act_row,
    output logic              pre_cmd,
    output logic [BANK_W-1:0] pre_bank
);
    localparam int RRD_W = $clog2(tRRD + 1);
    localparam int FAW_W = (tFAW > 2) ? $clog2(tFAW) : 1;
    localparam int RP_W  = (tRP > 2) ? $clog2(tRP) : 1;

    typedef enum logic [2:0] {
        ACT_IDLE, ACT_DECODE, ACT_HIT, ACT_PRE, ACT_WAIT_RP, ACT_WAIT_TIMING, ACT_CMD
    } act_state_t;

    act_state_t          state;
    logic [NUM_BANKS-1:0] bank_open;
    logic [ROW_W-1:0]    bank_row [NUM_BANKS];
    logic [RRD_W-1:0]    rrd_cnt;
    logic [FAW_W-1:0]    faw_cnt [4];
    logic [RP_W-1:0]     rp_cnt;
    logic                rrd_ok, faw_ok, auto_pre, open_now, hit;
    logic [1:0]          faw_slot;

    // rrd_cnt/faw_cnt are loaded on the edge that raises act_rdy, so a check made in
    // ACT_WAIT_TIMING already accounts for the one-cycle hop into ACT_CMD.
    always_comb begin
        rrd_ok   = rrd_cnt >= RRD_W'(tRRD - 1);
        faw_ok   = 1'b0;
        faw_slot = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (faw_cnt[i] == '0 && !faw_ok) begin
                faw_ok   = 1'b1;
                faw_slot = 2'(i);
            end
        end
        auto_pre = (act_rw == RDA_R) || (act_rw == WRA_R);
        open_now = bank_open[act_bank] && !close_all;
        hit      = open_now && (bank_row[act_bank] == act_row);
    end

    always_ff @(posedge CK_t) begin
        if (reset) begin
            state      <= ACT_IDLE;
            req_ready  <= 1'b1;
            act_rdy    <= 1'b0;
            no_act_rdy <= 1'b0;
            pre_cmd    <= 1'b0;
            act_rw     <= '0;
            act_bank   <= '0;
            act_row    <= '0;
            pre_bank   <= '0;
            bank_open  <= '0;
            rrd_cnt    <= RRD_W'(tRRD);
            rp_cnt     <= '0;
            for (int unsigned i = 0; i < NUM_BANKS; i++) bank_row[i] <= '0;
            for (int unsigned i = 0; i < 4; i++) faw_cnt[i] <= '0;
        end else begin
            act_rdy    <= 1'b0;
            no_act_rdy <= 1'b0;
            pre_cmd    <= 1'b0;
            if (rrd_cnt < RRD_W'(tRRD)) rrd_cnt <= rrd_cnt + 1'b1;
            for (int unsigned i = 0; i < 4; i++)
                if (faw_cnt[i] != '0) faw_cnt[i] <= faw_cnt[i] - 1'b1;
            // State-specific bank writes below override this clear (ACT_CMD wins).
            if (close_all) bank_open <= '0;

            case (state)
                ACT_IDLE: begin
                    if (req_valid) begin
                        act_rw    <= req_rw;
                        act_bank  <= req_bank;
                        act_row   <= req_row;
                        req_ready <= 1'b0;
                        state     <= ACT_DECODE;
                    end
                end
                ACT_DECODE: begin
                    if (hit) begin
                        no_act_rdy <= 1'b1;
                        state      <= ACT_HIT;
                    end else if (open_now) begin
                        pre_cmd  <= 1'b1;
                        pre_bank <= act_bank;
                        state    <= ACT_PRE;
                    end else begin
                        state <= ACT_WAIT_TIMING;
                    end
                end
                ACT_HIT: begin
                    if (auto_pre) bank_open[act_bank] <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= ACT_IDLE;
                end
                ACT_PRE: begin
                    bank_open[act_bank] <= 1'b0;
                    rp_cnt <= '0;
                    state  <= ACT_WAIT_RP;
                end
                ACT_WAIT_RP: begin
                    if (rp_cnt == RP_W'(tRP - 2)) state <= ACT_WAIT_TIMING;
                    else rp_cnt <= rp_cnt + 1'b1;
                end
                ACT_WAIT_TIMING: begin
                    if (rrd_ok && faw_ok) begin
                        act_rdy           <= 1'b1;
                        rrd_cnt           <= '0;
                        faw_cnt[faw_slot] <= FAW_W'(tFAW - 1);
                        state             <= ACT_CMD;
                    end
                end
                ACT_CMD: begin
                    bank_open[act_bank] <= !auto_pre;
                    bank_row[act_bank]  <= act_row;
                    req_ready <= 1'b1;
                    state     <= ACT_IDLE;
                end
                default: state <= ACT_IDLE;
            endcase
        end
    end
endmodule
